// File: rtl/layer_addr_seq_if.sv
// Memory-side strobe bundle driven by layer_addr_seq: one enable/address group per buffer.
// Each enable is a one-cycle valid strobe with no ready; its address is meaningful only while it is high and reads 0 otherwise.
interface layer_addr_seq_if #(
    parameter int X_ADDR_W = 13,
    parameter int W_ADDR_W = 16,
    parameter int T_ADDR_W = 7,
    parameter int Y_ADDR_W = 10
);
    logic                x_en;
    logic [X_ADDR_W-1:0] x_addr;
    logic                w_en;
    logic [W_ADDR_W-1:0] w_addr;
    logic                t_en;
    logic                t_wen;
    logic [T_ADDR_W-1:0] t_addr;
    logic                y_en;
    logic                y_wen;
    logic [Y_ADDR_W-1:0] y_addr;

    modport master (
        output x_en, x_addr, w_en, w_addr,
        output t_en, t_wen, t_addr, y_en, y_wen, y_addr
    );

    modport slave (
        input x_en, x_addr, w_en, w_addr,
        input t_en, t_wen, t_addr, y_en, y_wen, y_addr
    );
endinterface

// File: rtl/layer_addr_seq.sv
// Per-layer address sequencer: read sweep (input/temp + weights), wait for the MAC array, write sweep (temp/result).
// Define LAYER_ADDR_SEQ_BOUNDS_CHK_EN to add the sticky err output flagging temp-buffer overruns at start.
module layer_addr_seq #(
    parameter int X_ADDR_W     = 13,
    parameter int W_ADDR_W     = 16,
    parameter int T_ADDR_W     = 7,
    parameter int Y_ADDR_W     = 10,
    parameter int CNT_W        = 10,
    parameter int X_PIC_STRIDE = 784,
    parameter int Y_PIC_STRIDE = 40,
    parameter int Y_STEP       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    rows,
    input  logic [CNT_W-1:0]    cols,
    input  logic [W_ADDR_W-1:0] w_base,
    input  logic                first_layer,
    input  logic                last_layer,
    input  logic [3:0]          pic_idx,
    input  logic                stall,
    input  logic                mac_done,
    layer_addr_seq_if.master    mem,
    output logic                busy,
    output logic                rd_last,
    output logic                done,
    output logic [2:0]          state_dbg
`ifdef LAYER_ADDR_SEQ_BOUNDS_CHK_EN
    ,
    output logic                err
`endif
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      rows_q, cols_q;
    logic [W_ADDR_W-1:0]   wb_q;
    logic                  first_q, last_q;
    logic [3:0]            pic_q;

    logic                  latch, rd_issue, wr_issue, rd_last_d, done_d;
    logic                  cfg_sel, first_eff;
    logic [3:0]            pic_eff;
    logic [W_ADDR_W-1:0]   wb_eff;
    logic                  x_en_d, t_rd_d, t_wr_d, y_en_d;
    logic [X_ADDR_W-1:0]   x_next;
    logic [W_ADDR_W-1:0]   w_next;
    logic [T_ADDR_W-1:0]   t_next;
    logic [Y_ADDR_W-1:0]   y_next;

    assign state_dbg = state_q;

    // The first read is emitted on the accepting edge, so it must see the live config inputs.
    assign cfg_sel   = (state_q == IDLE);
    assign first_eff = cfg_sel ? first_layer : first_q;
    assign pic_eff   = cfg_sel ? pic_idx : pic_q;
    assign wb_eff    = cfg_sel ? w_base : wb_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        rd_issue  = 1'b0;
        wr_issue  = 1'b0;
        rd_last_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    cnt_d = '0;
                    if (rows != '0) begin
                        rd_issue  = 1'b1;
                        rd_last_d = (rows == CNT_W'(1));
                        state_d   = rd_last_d ? WAIT : RD;
                        cnt_d     = rd_last_d ? '0 : CNT_W'(1);
                    end else begin
                        state_d = (cols == '0) ? FIN : WAIT;
                    end
                end
            end
            RD: begin
                if (!stall) begin
                    rd_issue = 1'b1;
                    if (cnt_q == rows_q - CNT_W'(1)) begin
                        rd_last_d = 1'b1;
                        state_d   = WAIT;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                // A mac_done landing with the final read strobe belongs to no accepted wait.
                if (mac_done && !rd_last)
                    state_d = (cols_q == '0) ? FIN : WR;
            end
            WR: begin
                if (!stall) begin
                    wr_issue = 1'b1;
                    if (cnt_q == cols_q - CNT_W'(1)) begin
                        state_d = FIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign x_en_d = rd_issue && first_eff;
    assign t_rd_d = rd_issue && !first_eff;
    assign t_wr_d = wr_issue && !last_q;
    assign y_en_d = wr_issue && last_q;

    assign x_next = X_ADDR_W'(32'(pic_eff) * 32'(X_PIC_STRIDE) + 32'(cnt_q));
    assign w_next = W_ADDR_W'(32'(wb_eff) + 32'(cnt_q));
    assign t_next = T_ADDR_W'(cnt_q);
    assign y_next = Y_ADDR_W'(32'(pic_q) * 32'(Y_PIC_STRIDE) + 32'(Y_STEP) * 32'(cnt_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            wb_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            pic_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                rows_q  <= rows;
                cols_q  <= cols;
                wb_q    <= w_base;
                first_q <= first_layer;
                last_q  <= last_layer;
                pic_q   <= pic_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.x_en   <= 1'b0;
            mem.x_addr <= '0;
            mem.w_en   <= 1'b0;
            mem.w_addr <= '0;
            mem.t_en   <= 1'b0;
            mem.t_wen  <= 1'b0;
            mem.t_addr <= '0;
            mem.y_en   <= 1'b0;
            mem.y_wen  <= 1'b0;
            mem.y_addr <= '0;
            busy       <= 1'b0;
            rd_last    <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem.x_en   <= x_en_d;
            mem.x_addr <= x_en_d ? x_next : '0;
            mem.w_en   <= rd_issue;
            mem.w_addr <= rd_issue ? w_next : '0;
            mem.t_en   <= t_rd_d || t_wr_d;
            mem.t_wen  <= t_wr_d;
            mem.t_addr <= (t_rd_d || t_wr_d) ? t_next : '0;
            mem.y_en   <= y_en_d;
            mem.y_wen  <= y_en_d;
            mem.y_addr <= y_en_d ? y_next : '0;
            // busy spans the done cycle as well as every non-idle state.
            busy       <= (state_d != IDLE) || done_d;
            rd_last    <= rd_last_d;
            done       <= done_d;
        end
    end

`ifdef LAYER_ADDR_SEQ_BOUNDS_CHK_EN
    localparam int unsigned T_LIM = 32'd1 << T_ADDR_W;

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (cfg_sel && start &&
                 ((!first_layer && 32'(rows) > T_LIM) || (!last_layer && 32'(cols) > T_LIM)))
            err <= 1'b1;
    end
`endif

endmodule
